rr_rsp_router: RTL and testbench
================================

Name: rr_rsp_router

Overview:
- Return-path companion to the round-robin request arbiter.
- The arbiter grants one of PORT_NUM requesters per round and forwards that request to a shared, in-order resource (e.g. SRAM bank or global buffer).
- This block records each granted port index in an in-order tag FIFO, accepts the resource's responses, and steers each response back to the requester that issued it.
- It also backpressures the arbiter when the number of outstanding requests reaches DEPTH.

Parameters:
- PORT_NUM, 16, number of requester ports; must match the arbiter REQ_WIDTH.
- DATA_WIDTH, 128, response payload width.
- DEPTH, 8, maximum outstanding requests (tag FIFO entries); power of two, at least 2.
- PW, $clog2(PORT_NUM), port index width (derived).
- CW, $clog2(DEPTH)+1, outstanding-count width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- arb_vld  in  1  request granted and issued to the resource this cycle; arbiter arb_round.
- arb_port  in  PW  granted port index, valid with arb_vld.
- tag_full  out  1  outstanding == DEPTH; the arbiter must hold arb_round low while high.
- rsp_vld  in  1  response valid from the resource.
- rsp_dat  in  DATA_WIDTH  response payload.
- rsp_rdy  out  1  block accepts the response.
- port_vld  out  PORT_NUM  one-hot response valid per requester.
- port_dat  out  DATA_WIDTH  payload, broadcast to all ports.
- port_rdy  in  PORT_NUM  per-requester accept.
- outstanding  out  CW  tags issued whose response has not yet been accepted.
- err_ovf  out  1  sticky: arb_vld seen while tag_full.
- err_unf  out  1  sticky: rsp_vld seen while the tag FIFO is empty.

Behaviour:
- Reset, synchronous, rst high at a clk edge:
  - FIFO pointers, outstanding, port_vld, err_ovf and err_unf go to 0.
  - port_dat goes to 0.
  - Reset mid-operation discards all tags and any held response; the resource side is reset together with this block.
- Tag push:
  - Push occurs when arb_vld && !tag_full; arb_port is written at the write pointer.
  - arb_vld && tag_full: no push, err_ovf set.
  - Full blocks the push even if a pop occurs in the same cycle. tag_full is registered-state derived, never combinationally from the pop.
- Output stage, one-entry register:
  - Fields: out_vld, out_port, out_dat.
  - port_vld = out_vld ? (1 << out_port) : 0.
  - Output drain: out_vld && port_rdy[out_port].
- rsp_rdy = !fifo_empty && (!out_vld || port_rdy[out_port]).
  - rsp_rdy is combinational from state and port_rdy only, never from rsp_vld.
- Response accept (rsp_vld && rsp_rdy):
  - Pops the head tag.
  - Loads out_port = head tag, out_dat = rsp_dat, out_vld = 1 at the next edge.
- Latency and throughput:
  - Accepted response appears on port_vld/port_dat exactly 1 cycle later.
  - Sustained 1 response/cycle when the destination ports are ready.
- Drain without a new accept: out_vld clears; port_dat holds its last value.
- rsp_vld while fifo_empty:
  - rsp_rdy = 0, so the response is stalled, not dropped.
  - err_unf set.
- Tag bypass: a tag pushed in cycle N is poppable from cycle N+1; there is no same-cycle bypass.
- outstanding:
  - Increments on push, decrements on response accept; both in one cycle leaves it unchanged.
  - Range is 0..DEPTH.
- Empty/full detection: pointers are log2(DEPTH)+1 bits with wrap bit.
  - Empty when the pointers are equal.
  - Full when the MSBs differ and the remaining bits are equal.
- Ordering: responses are delivered strictly in grant order; no reordering.
- Errors: both flags are sticky until rst and have no functional effect beyond the stalls above.

Test Plan:
- Ordered return: push ports 3, 7, 0, then rsp_dat = A, B, C back-to-back with all port_rdy = 1 → port_vld = 0x0008 / A, 0x0080 / B, 0x0001 / C on consecutive cycles, each one cycle after its accept; outstanding ends at 0.
- Full/backpressure, DEPTH = 8: push 8 tags with no responses → tag_full = 1 and outstanding = 8. Ninth arb_vld → no push and err_ovf = 1. One response accepted → tag_full = 0 the next cycle.
- Port stall: pending responses for port 5 then port 2, port_rdy[5] = 0 for 4 cycles → port_vld = 0x0020 and port_dat held for 4 cycles, rsp_rdy = 0. Second response is accepted in the cycle port_rdy[5] rises and appears at port 2 the following cycle.
- Simultaneous push and pop at outstanding = 4 → outstanding stays 4. Pointers wrap correctly across 20 mixed cycles, checked against a reference queue.
- Underflow: rsp_vld = 1 with an empty FIFO → rsp_rdy = 0 and err_unf = 1. Push tag 9 → response accepted the next cycle and delivered with port_vld = 0x0200.
- Reset mid-stream: rst for 1 cycle with 3 tags pending and out_vld = 1 → the next cycle shows port_vld = 0, outstanding = 0, tag_full = 0, both error flags 0, and rsp_rdy = 0.

Source files
------------

// File: rtl/rr_rsp_router_if.sv
// Bundle of the arbiter grant, resource response and per-requester return
// signals around rr_rsp_router.
interface rr_rsp_router_if #(
  parameter int PORT_NUM   = 16,
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 8
);
  localparam int PW = $clog2(PORT_NUM);
  localparam int CW = $clog2(DEPTH) + 1;

  // arbiter side
  logic                  arb_vld;
  logic [PW-1:0]         arb_port;
  logic                  tag_full;

  // resource response side
  logic                  rsp_vld;
  logic [DATA_WIDTH-1:0] rsp_dat;
  logic                  rsp_rdy;

  // requester return side
  logic [PORT_NUM-1:0]   port_vld;
  logic [DATA_WIDTH-1:0] port_dat;
  logic [PORT_NUM-1:0]   port_rdy;

  // status
  logic [CW-1:0]         outstanding;
  logic                  err_ovf;
  logic                  err_unf;

  // router view
  modport slave (
    input  arb_vld, arb_port, rsp_vld, rsp_dat, port_rdy,
    output tag_full, rsp_rdy, port_vld, port_dat, outstanding, err_ovf, err_unf
  );

  // environment view (arbiter + resource + requesters)
  modport master (
    output arb_vld, arb_port, rsp_vld, rsp_dat, port_rdy,
    input  tag_full, rsp_rdy, port_vld, port_dat, outstanding, err_ovf, err_unf
  );
endinterface

// File: rtl/rr_rsp_router.sv
// Return-path router: records granted port indices in an in-order tag FIFO and
// steers each in-order resource response back to the requester that issued it.
module rr_rsp_router #(
  parameter int PORT_NUM   = 16,
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 8
) (
  input  logic            clk,
  input  logic            rst,
  rr_rsp_router_if.slave  bus
);
  localparam int PW = $clog2(PORT_NUM);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PW-1:0]         r_tag_mem [DEPTH];
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic                  r_out_vld;
  logic [PW-1:0]         r_out_port;
  logic [DATA_WIDTH-1:0] r_out_dat;
  logic                  r_err_ovf;
  logic                  r_err_unf;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_out_free;
  logic [PW-1:0]         w_head;
  logic [PORT_NUM-1:0]   w_port_vld;

  // Pointers carry a wrap bit so full and empty are distinguishable.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_head     = r_tag_mem[r_rd_ptr[AW-1:0]];
  assign w_out_free = !r_out_vld || bus.port_rdy[r_out_port];
  assign w_push     = bus.arb_vld && !w_full;
  assign w_pop      = bus.rsp_vld && bus.rsp_rdy;

  // Ready never looks at rsp_vld, so the resource sees no combinational loop.
  assign bus.rsp_rdy     = !w_empty && w_out_free;
  assign bus.tag_full    = w_full;
  assign bus.outstanding = CW'(r_wr_ptr - r_rd_ptr);
  assign bus.port_dat    = r_out_dat;
  assign bus.err_ovf     = r_err_ovf;
  assign bus.err_unf     = r_err_unf;

  generate
    for (genvar gi = 0; gi < PORT_NUM; gi++) begin : g_port_vld
      assign w_port_vld[gi] = r_out_vld && (r_out_port == PW'(gi));
    end
  endgenerate

  assign bus.port_vld = w_port_vld;

  // Tag storage needs no reset: only entries between the pointers are read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag_mem[r_wr_ptr[AW-1:0]] <= bus.arb_port;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_out_vld  <= 1'b0;
      r_out_port <= '0;
      r_out_dat  <= '0;
      r_err_ovf  <= 1'b0;
      r_err_unf  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_out_vld  <= 1'b1;
        r_out_port <= w_head;
        r_out_dat  <= bus.rsp_dat;
      end else if (r_out_vld && bus.port_rdy[r_out_port]) begin
        // port_dat intentionally keeps its last value after a drain
        r_out_vld <= 1'b0;
      end
      if (bus.arb_vld && w_full) begin
        r_err_ovf <= 1'b1;
      end
      if (bus.rsp_vld && w_empty) begin
        r_err_unf <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rr_rsp_router.sv
// Directed bench for rr_rsp_router: ordering, full/backpressure, port stall,
// pointer wrap against a reference queue, underflow and mid-stream reset.
module tb_rr_rsp_router;
  localparam int PORT_NUM   = 16;
  localparam int DATA_WIDTH = 128;
  localparam int DEPTH      = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  int          q[$];
  int          head;
  logic [3:0]  port_v;
  logic        push_v, pop_v, exp_rdy, exp_pop, exp_push;
  int          guard;

  always #5 clk = ~clk;

  rr_rsp_router_if #(.PORT_NUM(PORT_NUM), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) bus ();

  rr_rsp_router #(.PORT_NUM(PORT_NUM), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tag(input logic [3:0] p);
    bus.arb_vld  = 1'b1;
    bus.arb_port = p;
    tick();
    bus.arb_vld  = 1'b0;
  endtask

  initial begin
    bus.arb_vld  = 1'b0;
    bus.arb_port = '0;
    bus.rsp_vld  = 1'b0;
    bus.rsp_dat  = '0;
    bus.port_rdy = '1;

    // reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_port_vld", bus.port_vld, 0);
    chk("rst_port_dat", bus.port_dat, 0);
    chk("rst_outst", bus.outstanding, 0);
    chk("rst_full", bus.tag_full, 0);
    chk("rst_ovf", bus.err_ovf, 0);
    chk("rst_unf", bus.err_unf, 0);
    chk("rst_rsp_rdy", bus.rsp_rdy, 0);

    // ordered return: ports 3, 7, 0 then responses A, B, C back-to-back
    push_tag(4'd3);
    push_tag(4'd7);
    push_tag(4'd0);
    chk("ord_outst3", bus.outstanding, 3);
    bus.rsp_vld = 1'b1;
    bus.rsp_dat = 128'hAAAA;
    #1 chk("ord_rdy", bus.rsp_rdy, 1);
    tick();
    chk("ord_vld_a", bus.port_vld, 16'h0008);
    chk("ord_dat_a", bus.port_dat, 128'hAAAA);
    bus.rsp_dat = 128'hBBBB;
    tick();
    chk("ord_vld_b", bus.port_vld, 16'h0080);
    chk("ord_dat_b", bus.port_dat, 128'hBBBB);
    bus.rsp_dat = 128'hCCCC;
    tick();
    chk("ord_vld_c", bus.port_vld, 16'h0001);
    chk("ord_dat_c", bus.port_dat, 128'hCCCC);
    chk("ord_outst0", bus.outstanding, 0);
    bus.rsp_vld = 1'b0;
    tick();
    chk("ord_drained", bus.port_vld, 0);
    chk("ord_dat_hold", bus.port_dat, 128'hCCCC);

    // full / backpressure
    for (int i = 0; i < 8; i++) push_tag(4'(i));
    chk("full_flag", bus.tag_full, 1);
    chk("full_outst", bus.outstanding, 8);
    push_tag(4'd15);
    chk("full_no_push", bus.outstanding, 8);
    chk("full_ovf", bus.err_ovf, 1);
    // push attempt and accept in the same cycle: full still blocks the push
    bus.arb_vld  = 1'b1;
    bus.arb_port = 4'd15;
    bus.rsp_vld  = 1'b1;
    bus.rsp_dat  = 128'hF00;
    #1 chk("full_rdy", bus.rsp_rdy, 1);
    chk("full_still", bus.tag_full, 1);
    tick();
    bus.arb_vld = 1'b0;
    chk("full_clear", bus.tag_full, 0);
    chk("full_outst7", bus.outstanding, 7);
    chk("full_vld0", bus.port_vld, 16'h0001);
    for (int i = 1; i < 8; i++) begin
      bus.rsp_dat = 128'hF00 + 128'(i);
      tick();
      chk("full_drain_vld", bus.port_vld, 128'(1) << i);
      chk("full_drain_dat", bus.port_dat, 128'hF00 + 128'(i));
    end
    chk("full_outst0", bus.outstanding, 0);
    bus.rsp_vld = 1'b0;
    #1 chk("full_empty_rdy", bus.rsp_rdy, 0);
    tick();

    // port stall: port 5 held off for 4 cycles, port 2 queued behind it
    push_tag(4'd5);
    push_tag(4'd2);
    bus.rsp_vld = 1'b1;
    bus.rsp_dat = 128'h5555;
    tick();
    bus.port_rdy[5] = 1'b0;
    bus.rsp_dat     = 128'h2222;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_rdy", bus.rsp_rdy, 0);
      chk("stall_vld", bus.port_vld, 16'h0020);
      chk("stall_dat", bus.port_dat, 128'h5555);
      tick();
    end
    bus.port_rdy[5] = 1'b1;
    #1 chk("stall_release_rdy", bus.rsp_rdy, 1);
    tick();
    bus.rsp_vld = 1'b0;
    chk("stall_vld2", bus.port_vld, 16'h0004);
    chk("stall_dat2", bus.port_dat, 128'h2222);
    tick();
    chk("stall_done", bus.port_vld, 0);

    // simultaneous push/pop at outstanding 4, then mixed traffic with wrap
    q.delete();
    for (int i = 10; i < 14; i++) begin
      push_tag(4'(i));
      q.push_back(i);
    end
    bus.arb_vld  = 1'b1;
    bus.arb_port = 4'd14;
    bus.rsp_vld  = 1'b1;
    bus.rsp_dat  = 128'h4444;
    tick();
    head = q.pop_front();
    q.push_back(14);
    chk("pp_outst4", bus.outstanding, 4);
    chk("pp_vld", bus.port_vld, 128'(1) << head);
    for (int i = 0; i < 20; i++) begin
      push_v = (i % 3) != 2;
      pop_v  = (i % 2) == 0;
      port_v = 4'((i * 5 + 1) % 16);
      bus.arb_vld  = push_v;
      bus.arb_port = port_v;
      bus.rsp_vld  = pop_v;
      bus.rsp_dat  = 128'h5000 + 128'(i);
      exp_rdy  = q.size() != 0;
      exp_pop  = pop_v && exp_rdy;
      exp_push = push_v && (q.size() < DEPTH);
      #1 chk("mix_rdy", bus.rsp_rdy, exp_rdy);
      if (exp_pop) head = q.pop_front();
      if (exp_push) q.push_back(int'(port_v));
      tick();
      chk("mix_outst", bus.outstanding, q.size());
      chk("mix_vld", bus.port_vld, exp_pop ? (128'(1) << head) : 128'(0));
      if (exp_pop) chk("mix_dat", bus.port_dat, 128'h5000 + 128'(i));
    end
    bus.arb_vld = 1'b0;
    bus.rsp_vld = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      bus.rsp_dat = 128'h6000 + 128'(guard);
      head = q.pop_front();
      tick();
      chk("mix_drain_vld", bus.port_vld, 128'(1) << head);
      guard++;
    end
    chk("mix_drain_bound", guard < 20, 1);
    bus.rsp_vld = 1'b0;
    chk("mix_outst0", bus.outstanding, 0);
    tick();

    // underflow: response with empty FIFO stalls, then tag 9 releases it
    bus.rsp_vld = 1'b1;
    bus.rsp_dat = 128'h9999;
    #1 chk("unf_rdy", bus.rsp_rdy, 0);
    tick();
    chk("unf_flag", bus.err_unf, 1);
    bus.arb_vld  = 1'b1;
    bus.arb_port = 4'd9;
    #1 chk("unf_no_bypass", bus.rsp_rdy, 0);
    tick();
    bus.arb_vld = 1'b0;
    #1 chk("unf_rdy_next", bus.rsp_rdy, 1);
    tick();
    bus.rsp_vld = 1'b0;
    chk("unf_vld", bus.port_vld, 16'h0200);
    chk("unf_dat", bus.port_dat, 128'h9999);
    tick();

    // reset mid-stream: 3 tags pending and a held response
    for (int i = 1; i < 5; i++) push_tag(4'(i));
    bus.rsp_vld = 1'b1;
    bus.rsp_dat = 128'hDEAD;
    tick();
    bus.rsp_vld = 1'b0;
    chk("mrst_pre_outst", bus.outstanding, 3);
    chk("mrst_pre_vld", bus.port_vld, 16'h0002);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_vld", bus.port_vld, 0);
    chk("mrst_outst", bus.outstanding, 0);
    chk("mrst_full", bus.tag_full, 0);
    chk("mrst_ovf", bus.err_ovf, 0);
    chk("mrst_unf", bus.err_unf, 0);
    chk("mrst_rdy", bus.rsp_rdy, 0);
    chk("mrst_dat", bus.port_dat, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
